// File: rtl/rca_pkg.sv
// Shared definitions for the nibble-serial ripple-carry adder.
// Optional feature macro: RCA_SEQ_OVF_EN (signed-overflow output).
package rca_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } seq_state_e;

   // Two's-complement overflow: operands agree in sign but the sum does not.
   function automatic logic signedOvf(input logic aMsb, input logic bMsb, input logic sumMsb);
      return (aMsb == bMsb) && (sumMsb != aMsb);
   endfunction

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// 4-bit ripple-carry slice: one full adder per bit, carry chained LSB to MSB.
module ripple_carry_adder_4bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);

   logic [4:0] carry;

   // Ripple the carry through four full-adder stages.
   always_comb begin
      carry    = '0;
      sum_o    = '0;
      carry[0] = cin_i;
      for (int i = 0; i < 4; i++) begin
         sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
         carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
      end
      cout_o = carry[4];
   end

endmodule

// File: rtl/rca_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder that feeds the 4-bit ripple slice one nibble
// per cycle, LSB first, with the inter-nibble carry held in a register.
// Optional feature macro: RCA_SEQ_OVF_EN adds the registered out_ovf port.
module rca_nibble_sequencer
   import rca_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
`ifdef RCA_SEQ_OVF_EN
   output logic             out_ovf,
`endif
   output logic             out_cout
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   seq_state_e           state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [WIDTH-1:0]     sum_q, sum_d;
   logic                 carry_q, carry_d;

   logic [NIBBLE_W-1:0]  sliceA;
   logic [NIBBLE_W-1:0]  sliceB;
   logic [NIBBLE_W-1:0]  sliceSum;
   logic                 sliceCout;
   logic                 lastNibble;

   // Select the current operand nibbles for the slice.
   always_comb begin
      sliceA     = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
      sliceB     = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
      lastNibble = (idx_q == LAST_IDX);
   end

   ripple_carry_adder_4bit uSlice (
      .a_i    (sliceA),
      .b_i    (sliceB),
      .cin_i  (carry_q),
      .sum_o  (sliceSum),
      .cout_o (sliceCout)
   );

   // Next-state logic for the IDLE -> ADD -> DONE sequence and its datapath.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               carry_d = in_cin;
               idx_d   = '0;
               sum_d   = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = sliceSum;
            carry_d = sliceCout;
            if (lastNibble) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any partial result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

`ifdef RCA_SEQ_OVF_EN
   logic ovf_q, ovf_d;

   // Overflow is captured alongside the final nibble and cleared on accept.
   always_comb begin
      ovf_d = ovf_q;
      if (state_q == IDLE && in_valid) begin
         ovf_d = 1'b0;
      end else if (state_q == ADD && lastNibble) begin
         ovf_d = signedOvf(a_q[WIDTH-1], b_q[WIDTH-1], sliceSum[NIBBLE_W-1]);
      end
   end

   // Overflow register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign out_ovf = ovf_q;
`endif

   // Outputs come straight from registers; in_ready is held low during reset.
   assign in_ready  = (state_q == IDLE) && rst_n;
   assign out_valid = (state_q == DONE);
   assign out_sum   = sum_q;
   assign out_cout  = carry_q;

endmodule
